// File: rtl/dma_chan_sched.sv
// Round-robin scheduler sharing one DMA transfer engine among 4 channels.
// A granted channel's descriptor is latched onto the engine address/control
// outputs, the engine is launched and supervised until end, error, abort or
// timeout, and a one-cycle done/err pulse is returned to the channel.
module dma_chan_sched #(
  parameter int ADDR_W  = 64,
  parameter int BLK_W   = 12,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk_in_1,
  input  logic                reset_1,
  input  logic [3:0]          req,
  input  logic [4*ADDR_W-1:0] req_addr_i,
  input  logic [4*ADDR_W-1:0] req_addr_o,
  input  logic [4*BLK_W-1:0]  req_size,
  input  logic [7:0]          req_tran,
  input  logic                stop_req,
  input  logic                busy,
  input  logic                end_2,
  input  logic                error_1,
  output logic                enable_2,
  output logic                stop_2,
  output logic [1:0]          tran_2,
  output logic [BLK_W-1:0]    block_size,
  output logic [ADDR_W-1:0]   addr_RAM_i,
  output logic [ADDR_W-1:0]   addr_RAM_o,
  output logic [3:0]          ack,
  output logic [3:0]          done,
  output logic [3:0]          err,
  output logic [1:0]          cur_ch,
  output logic                sched_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_RUN, S_ABORT, S_DONE, S_FAIL
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       rr_ptr;
  logic [15:0]      tmo_cnt;
  logic             gnt_vld;
  logic [1:0]       gnt_ch;
  logic [1:0]       scan_ch;
  logic [BLK_W-1:0] gnt_size;
  logic             grant;
  logic             tmo_hit;

  // Round-robin search: first requesting channel at or above the pointer, mod 4.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = rr_ptr;
    scan_ch = rr_ptr;
    for (int i = 3; i >= 0; i--) begin
      scan_ch = rr_ptr + i[1:0];
      if (req[scan_ch]) begin
        gnt_vld = 1'b1;
        gnt_ch  = scan_ch;
      end
    end
  end

  assign gnt_size = req_size[gnt_ch*BLK_W +: BLK_W];
  assign grant    = (state == S_IDLE) && gnt_vld;
  assign tmo_hit  = (tmo_cnt == 16'(TIMEOUT));

  // Next-state logic; abort requests win over busy while launching.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (gnt_vld) state_nxt = (gnt_size == '0) ? S_DONE : S_LAUNCH;
      S_LAUNCH: if (stop_req || tmo_hit) state_nxt = S_ABORT;
                else if (busy)           state_nxt = S_RUN;
      S_RUN:    if (error_1)                  state_nxt = S_FAIL;
                else if (end_2)               state_nxt = S_DONE;
                else if (stop_req || tmo_hit) state_nxt = S_ABORT;
      S_ABORT:  if (!busy) state_nxt = S_FAIL;
      S_DONE:   state_nxt = S_IDLE;
      S_FAIL:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign enable_2   = (state == S_LAUNCH);
  assign stop_2     = (state == S_ABORT);
  assign sched_busy = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk_in_1 or negedge reset_1) begin
    if (!reset_1) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Pointer, timeout counter, descriptor latch and registered channel pulses.
  always_ff @(posedge clk_in_1 or negedge reset_1) begin
    if (!reset_1) begin
      rr_ptr     <= '0;
      tmo_cnt    <= '0;
      tran_2     <= '0;
      block_size <= '0;
      addr_RAM_i <= '0;
      addr_RAM_o <= '0;
      cur_ch     <= '0;
      ack        <= '0;
      done       <= '0;
      err        <= '0;
    end else begin
      ack  <= grant ? (4'b0001 << gnt_ch) : 4'b0000;
      done <= (state == S_DONE) ? (4'b0001 << cur_ch) : 4'b0000;
      err  <= (state == S_FAIL) ? (4'b0001 << cur_ch) : 4'b0000;
      if (grant) begin
        rr_ptr     <= gnt_ch + 2'd1;
        tmo_cnt    <= '0;
        cur_ch     <= gnt_ch;
        tran_2     <= req_tran[gnt_ch*2 +: 2];
        block_size <= gnt_size;
        addr_RAM_i <= req_addr_i[gnt_ch*ADDR_W +: ADDR_W];
        addr_RAM_o <= req_addr_o[gnt_ch*ADDR_W +: ADDR_W];
      end else if ((state == S_LAUNCH || state == S_RUN) && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dma_chan_sched.sv
// Directed bench for dma_chan_sched with TIMEOUT shortened to 20 cycles.
module tb_dma_chan_sched;

  localparam int ADDR_W = 64;
  localparam int BLK_W  = 12;

  logic                clk_in_1 = 1'b0;
  logic                reset_1;
  logic [3:0]          req;
  logic [4*ADDR_W-1:0] req_addr_i;
  logic [4*ADDR_W-1:0] req_addr_o;
  logic [4*BLK_W-1:0]  req_size;
  logic [7:0]          req_tran;
  logic                stop_req, busy, end_2, error_1;
  logic                enable_2, stop_2;
  logic [1:0]          tran_2;
  logic [BLK_W-1:0]    block_size;
  logic [ADDR_W-1:0]   addr_RAM_i, addr_RAM_o;
  logic [3:0]          ack, done, err;
  logic [1:0]          cur_ch;
  logic                sched_busy;

  int n_cmp = 0;
  int n_bad = 0;

  dma_chan_sched #(.ADDR_W(ADDR_W), .BLK_W(BLK_W), .TIMEOUT(20)) dut (
    .clk_in_1(clk_in_1), .reset_1(reset_1), .req(req),
    .req_addr_i(req_addr_i), .req_addr_o(req_addr_o),
    .req_size(req_size), .req_tran(req_tran), .stop_req(stop_req),
    .busy(busy), .end_2(end_2), .error_1(error_1),
    .enable_2(enable_2), .stop_2(stop_2), .tran_2(tran_2),
    .block_size(block_size), .addr_RAM_i(addr_RAM_i), .addr_RAM_o(addr_RAM_o),
    .ack(ack), .done(done), .err(err), .cur_ch(cur_ch), .sched_busy(sched_busy)
  );

  always #5 clk_in_1 = ~clk_in_1;

  task automatic tick();
    @(posedge clk_in_1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_desc(input int ch, input logic [63:0] ai, input logic [63:0] ao,
                          input logic [11:0] sz, input logic [1:0] tr);
    req_addr_i[ch*ADDR_W +: ADDR_W] = ai;
    req_addr_o[ch*ADDR_W +: ADDR_W] = ao;
    req_size[ch*BLK_W +: BLK_W]     = sz;
    req_tran[ch*2 +: 2]             = tr;
  endtask

  initial begin
    int stop_early;
    reset_1 = 1'b0; req = '0; stop_req = 0; busy = 0; end_2 = 0; error_1 = 0;
    req_addr_i = '0; req_addr_o = '0; req_size = '0; req_tran = '0;
    for (int c = 0; c < 4; c++)
      set_desc(c, 64'h1000 + 64'(c), 64'h2000 + 64'(c), 12'd8 + 12'(c), 2'(c));

    // Reset state
    tick(); tick();
    chk("rst_ack", ack, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
    chk("rst_en", enable_2, 0); chk("rst_stop", stop_2, 0);
    chk("rst_busy", sched_busy, 0); chk("rst_cur", cur_ch, 0);
    chk("rst_addr_i", addr_RAM_i, 0); chk("rst_size", block_size, 0);
    reset_1 = 1'b1;
    tick();

    // Round robin with all requests held: ch0,1,2,3,0
    req = 4'b1111;
    tick();
    for (int n = 0; n < 5; n++) begin
      chk("rr_ack", ack, 64'(4'b0001 << (n % 4)));
      chk("rr_cur", cur_ch, 64'(n % 4));
      chk("rr_en", enable_2, 1);
      busy = 1;
      tick();
      chk("rr_en_drop", enable_2, 0);
      chk("rr_ack_once", ack, 0);
      end_2 = 1;
      tick();
      end_2 = 0; busy = 0;
      chk("rr_done_wait", done, 0);
      tick();
      chk("rr_done", done, 64'(4'b0001 << (n % 4)));
      chk("rr_ack_gap", ack, 0);
      if (n == 4) req = 4'b0000;
      tick();
    end
    chk("rr_idle_ack", ack, 0);
    chk("rr_idle_busy", sched_busy, 0);

    // Single request on ch1 (pointer now 1)
    set_desc(1, 64'h100, 64'h200, 12'd16, 2'b01);
    req = 4'b0010;
    tick();
    chk("s_ack", ack, 4'b0010); chk("s_en", enable_2, 1);
    chk("s_size", block_size, 16); chk("s_ai", addr_RAM_i, 64'h100);
    chk("s_ao", addr_RAM_o, 64'h200); chk("s_tran", tran_2, 2'b01);
    chk("s_cur", cur_ch, 1); chk("s_busy", sched_busy, 1);
    req = 4'b0000;
    tick();
    chk("s_en_hold", enable_2, 1); chk("s_ack_pulse", ack, 0);
    busy = 1;
    tick();
    chk("s_en_off", enable_2, 0);
    end_2 = 1;
    tick();
    end_2 = 0; busy = 0;
    tick();
    chk("s_done", done, 4'b0010); chk("s_idle", sched_busy, 0);
    chk("s_hold_ai", addr_RAM_i, 64'h100);
    tick();
    chk("s_done_pulse", done, 0);

    // Error and end together: error wins (pointer 2, request ch3)
    req = 4'b1000;
    tick();
    chk("e_ack", ack, 4'b1000);
    req = 4'b0000; busy = 1;
    tick();
    error_1 = 1; end_2 = 1;
    tick();
    error_1 = 0; end_2 = 0; busy = 0;
    tick();
    chk("e_err", err, 4'b1000); chk("e_done", done, 0);

    // Timeout on ch0 (pointer 0): abort entered 21 edges after grant edge
    set_desc(0, 64'h300, 64'h400, 12'd5, 2'b10);
    req = 4'b0001;
    tick();
    chk("t_ack", ack, 4'b0001);
    req = 4'b0000; busy = 1;
    stop_early = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (stop_2 !== 1'b0) stop_early++;
    end
    chk("t_no_early_stop", stop_early, 0);
    tick();
    chk("t_stop", stop_2, 1);
    end_2 = 1;
    tick();
    end_2 = 0;
    chk("t_stop_hold", stop_2, 1); chk("t_end_ignored", done, 0);
    busy = 0;
    tick();
    chk("t_stop_off", stop_2, 0);
    tick();
    chk("t_err", err, 4'b0001); chk("t_no_done", done, 0);

    // Zero size on ch2 (pointer 1 -> search 1,2)
    set_desc(2, 64'h500, 64'h600, 12'd0, 2'b11);
    req = 4'b0100;
    tick();
    chk("z_ack", ack, 4'b0100); chk("z_en", enable_2, 0);
    chk("z_done_wait", done, 0);
    req = 4'b0000;
    tick();
    chk("z_done", done, 4'b0100); chk("z_en2", enable_2, 0);

    // Reset asserted mid-RUN between edges (pointer 3 -> ch1)
    req = 4'b0010;
    tick();
    chk("r_ack", ack, 4'b0010);
    req = 4'b0000; busy = 1;
    tick();
    #2 reset_1 = 1'b0;
    #1;
    chk("r_busy", sched_busy, 0); chk("r_cur", cur_ch, 0);
    chk("r_ai", addr_RAM_i, 0); chk("r_size", block_size, 0);
    chk("r_en", enable_2, 0); chk("r_stop", stop_2, 0);
    tick();
    reset_1 = 1'b1; busy = 0;
    set_desc(1, 64'h700, 64'h800, 12'd0, 2'b00);
    req = 4'b1010;
    tick();
    chk("r_ptr_ack", ack, 4'b0010);
    req = 4'b0000;
    tick(); tick();
    req = 4'b0100;
    tick();
    chk("r_ch2_ack", ack, 4'b0100); chk("r_ch2_cur", cur_ch, 2);
    req = 4'b0000;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
